fetch_unit: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline, sitting directly upstream of decode (register file, control unit, sign extend). Owns the program counter, issues word-aligned requests to instruction memory over a req/ready handshake, and drives the IF/ID pipeline register (instruction, PC+4, valid). Honours a decode-stage stall from hazard detection and a branch redirect from the execute/memory stage. Discards in-flight fetches made stale by a redirect.

---
 rtl/mips_pkg.sv | 27 ++
 rtl/if_id_reg.sv | 28 ++
 rtl/fetch_unit.sv | 128 ++++++++++++
 tb/tb_fetch_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline stages.
// Holds the fetch FSM state, the IF/ID bundle and PC helpers.
package mips_pkg;

  localparam int          INSTR_W = 32;
  localparam logic [31:0] PC_INC  = 32'd4;
  localparam logic [INSTR_W-1:0] NOP = '0;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    KILL
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc4;
    logic               valid;
  } if_id_t;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load, flush (valid only), hold.
// Ports: clk, rst_n, load, flush, hold, d (next bundle), q (held bundle).
module if_id_reg
  import mips_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   flush,
  input  logic   hold,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.instr <= NOP;
      q.pc4   <= '0;
      q.valid <= 1'b0;
    end else if (flush) begin
      // Bubble: payload is kept, only the valid bit drops.
      q.valid <= 1'b0;
    end else if (load && !hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem req/ready handshake, IF/ID register.
// Ports: clk, rst_n, imem_*, stall, redirect(_pc), if_id_instr/pc4/valid.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ready,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [31:0]        if_id_pc4,
  output logic               if_id_valid
);

  fetch_state_t       state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        pend_q, pend_d;
  logic [INSTR_W-1:0] hold_q, hold_d;
  logic               run_q;

  logic        load, flush;
  if_id_t      nd, q;
  logic [31:0] pc_inc;
  logic [31:0] rpc;

  assign pc_inc = pc_q + PC_INC;
  assign rpc    = word_align(redirect_pc);

  // run_q keeps the request low until the first edge after reset release.
  assign imem_req  = run_q && (state_q != HOLD);
  assign imem_addr = pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= word_align(RESET_PC);
      pend_q  <= '0;
      hold_q  <= NOP;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      hold_q  <= hold_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pend_d   = pend_q;
    hold_d   = hold_q;
    load     = 1'b0;
    flush    = 1'b0;
    nd.instr = imem_rdata;
    nd.pc4   = pc_inc;
    nd.valid = 1'b1;
    if (run_q) begin
      unique case (state_q)
        FETCH: begin
          if (redirect) begin
            flush = 1'b1;
            if (imem_ready) begin
              pc_d = rpc;
            end else begin
              pend_d  = rpc;
              state_d = KILL;
            end
          end else if (imem_ready && !stall) begin
            load = 1'b1;
            pc_d = pc_inc;
          end else if (imem_ready) begin
            hold_d  = imem_rdata;
            state_d = HOLD;
          end else if (!stall) begin
            flush = 1'b1;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc_d    = rpc;
            flush   = 1'b1;
            state_d = FETCH;
          end else if (!stall) begin
            load     = 1'b1;
            nd.instr = hold_q;
            pc_d     = pc_inc;
            state_d  = FETCH;
          end
        end
        KILL: begin
          // Stale address stays on the bus until the memory answers.
          flush = 1'b1;
          if (imem_ready) begin
            pc_d    = redirect ? rpc : pend_q;
            state_d = FETCH;
          end else if (redirect) begin
            pend_d = rpc;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  if_id_reg u_if_id (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .flush (flush),
    .hold  (stall),
    .d     (nd),
    .q     (q)
  );

  assign if_id_instr = q.instr;
  assign if_id_pc4   = q.pc4;
  assign if_id_valid = q.valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit.
// Memory returns addr ^ 32'h8C00_0000 so each word is traceable.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;

  int errors = 0;
  int checks = 0;

  fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_id_instr (if_id_instr),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_at(input logic [31:0] a);
    return a ^ 32'h8C00_0000;
  endfunction

  assign imem_rdata = instr_at(imem_addr);

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag,
                          input logic [31:0] ins,
                          input logic [31:0] pc4,
                          input logic v);
    chk({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, v});
    if (v) begin
      chk({tag, ".instr"}, if_id_instr, ins);
      chk({tag, ".pc4"}, if_id_pc4, pc4);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    imem_ready  = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    #1;
    chk("rst.req", {31'b0, imem_req}, 32'h0);
    chk("rst.valid", {31'b0, if_id_valid}, 32'h0);
    chk("rst.instr", if_id_instr, 32'h0);
    chk("rst.pc4", if_id_pc4, 32'h0);
    step();
    step();
    chk("rst.req_held", {31'b0, imem_req}, 32'h0);
    rst_n = 1'b1;
    chk("rel.req_pre", {31'b0, imem_req}, 32'h0);

    // Zero-wait streaming
    step();
    chk("s.req", {31'b0, imem_req}, 32'h1);
    chk("s.addr0", imem_addr, 32'h0);
    step();
    chk_ifid("s.i0", instr_at(32'h0), 32'h4, 1'b1);
    chk("s.addr4", imem_addr, 32'h4);
    step();
    chk_ifid("s.i4", instr_at(32'h4), 32'h8, 1'b1);
    chk("s.addr8", imem_addr, 32'h8);

    // Wait states at pc=8
    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("w.bubble", {31'b0, if_id_valid}, 32'h0);
      chk("w.addr", imem_addr, 32'h8);
      chk("w.req", {31'b0, imem_req}, 32'h1);
    end
    imem_ready = 1'b1;
    step();
    chk_ifid("w.i8", instr_at(32'h8), 32'hC, 1'b1);
    chk("w.addr12", imem_addr, 32'hC);

    // Stall 3 cycles at pc=12
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_ifid("st.frozen", instr_at(32'h8), 32'hC, 1'b1);
      chk("st.req", {31'b0, imem_req}, 32'h0);
    end
    stall = 1'b0;
    step();
    chk_ifid("st.i12", instr_at(32'hC), 32'h10, 1'b1);
    chk("st.addr16", imem_addr, 32'h10);
    chk("st.req1", {31'b0, imem_req}, 32'h1);
    step();
    chk_ifid("n.i16", instr_at(32'h10), 32'h14, 1'b1);
    chk("n.addr20", imem_addr, 32'h14);

    // Redirect while pending at pc=20
    imem_ready  = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    chk("k.valid", {31'b0, if_id_valid}, 32'h0);
    chk("k.addr", imem_addr, 32'h14);
    chk("k.req", {31'b0, imem_req}, 32'h1);
    step();
    chk("k.valid2", {31'b0, if_id_valid}, 32'h0);
    chk("k.addr2", imem_addr, 32'h14);
    imem_ready = 1'b1;
    step();
    chk("k.drop", {31'b0, if_id_valid}, 32'h0);
    chk("k.tgt", imem_addr, 32'h100);
    step();
    chk_ifid("k.i100", instr_at(32'h100), 32'h104, 1'b1);
    chk("k.addr104", imem_addr, 32'h104);

    // Redirect and stall together
    redirect    = 1'b1;
    stall       = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    stall    = 1'b0;
    chk("rs.valid", {31'b0, if_id_valid}, 32'h0);
    chk("rs.addr", imem_addr, 32'h200);
    step();
    chk_ifid("rs.i200", instr_at(32'h200), 32'h204, 1'b1);

    // PC wrap
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    chk("wr.addr", imem_addr, 32'hFFFF_FFFC);
    step();
    chk_ifid("wr.ifid", instr_at(32'hFFFF_FFFC), 32'h0, 1'b1);
    chk("wr.addr0", imem_addr, 32'h0);

    // Reset asserted mid-KILL
    imem_ready  = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    chk("mk.req", {31'b0, imem_req}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mk.req_rst", {31'b0, imem_req}, 32'h0);
    chk("mk.valid", {31'b0, if_id_valid}, 32'h0);
    chk("mk.instr", if_id_instr, 32'h0);
    chk("mk.pc4", if_id_pc4, 32'h0);
    chk("mk.addr", imem_addr, 32'h0);
    #2;
    rst_n      = 1'b1;
    imem_ready = 1'b1;
    step();
    chk("mk.req_rel", {31'b0, imem_req}, 32'h1);
    chk("mk.addr_rel", imem_addr, 32'h0);
    step();
    chk_ifid("mk.i0", instr_at(32'h0), 32'h4, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
